// File: rtl/des_perm_pipe.sv
// Elastic pipeline applying DES bit permutations (P, IP, FP) to a 64-bit word.
// Optional macro DES_PERM_INVERSE_EN turns mode 11 into inverse P instead of bypass.
module des_perm_pipe #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             busy,
  output logic [CNT_W-1:0] accept_cnt
);

  // Tables hold 1-based source bit numbers, bit 1 = MSB.
  localparam logic [0:31][5:0] P_T = {
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };

  localparam logic [0:63][6:0] IP_T = {
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
    7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
    7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
    7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
  };

  localparam logic [0:63][6:0] FP_T = {
    7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
    7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
    7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
    7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
    7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
  };

  // MSB-first position k lives at vector bit ~k.
  function automatic logic [63:0] perm64(input logic [63:0] d, input logic [0:63][6:0] t);
    logic [63:0] r;
    logic [5:0]  k;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      k = 6'(i);
      r[~k] = d[6'(7'd64 - t[k])];
    end
    return r;
  endfunction

  function automatic logic [31:0] pbox(input logic [31:0] h);
    logic [31:0] r;
    logic [4:0]  k;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      k = 5'(i);
      r[~k] = h[5'(6'd32 - P_T[k])];
    end
    return r;
  endfunction

`ifdef DES_PERM_INVERSE_EN
  function automatic logic [31:0] pbox_inv(input logic [31:0] h);
    logic [31:0] r;
    logic [4:0]  k;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      k = 5'(i);
      r[5'(6'd32 - P_T[k])] = h[~k];
    end
    return r;
  endfunction
`endif

  logic [63:0]       perm;
  logic [STAGES-1:0] vld_q;
  logic [63:0]       dat_q [STAGES];
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] up_v;
  logic [63:0]       up_d  [STAGES];
  logic [CNT_W-1:0]  accept_cnt_q;
  logic              accept;

  always_comb begin
    perm = '0;
    unique case (in_mode)
      2'b00:   perm = {pbox(in_data[63:32]), 32'h0};
      2'b01:   perm = perm64(in_data, IP_T);
      2'b10:   perm = perm64(in_data, FP_T);
`ifdef DES_PERM_INVERSE_EN
      2'b11:   perm = {pbox_inv(in_data[63:32]), 32'h0};
`else
      2'b11:   perm = in_data;
`endif
      default: perm = '0;
    endcase
  end

  // A stage may load whenever any stage from it to the output has a hole,
  // so bubbles collapse while the consumer is stalled.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      rdy[s] = out_ready;
      for (int j = s; j < STAGES; j++) begin
        if (!vld_q[j]) rdy[s] = 1'b1;
      end
    end
  end

  always_comb begin
    up_v[0] = in_valid;
    up_d[0] = perm;
    for (int s = 1; s < STAGES; s++) begin
      up_v[s] = vld_q[s-1];
      up_d[s] = dat_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) dat_q[s] <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (rdy[s]) begin
          vld_q[s] <= up_v[s];
          if (up_v[s]) dat_q[s] <= up_d[s];
        end
      end
    end
  end

  assign in_ready = rdy[0] & ~rst;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_cnt_q <= '0;
    end else if (accept) begin
      accept_cnt_q <= accept_cnt_q + 1'b1;
    end
  end

  assign out_valid  = vld_q[STAGES-1];
  assign out_data   = dat_q[STAGES-1];
  assign busy       = |vld_q;
  assign accept_cnt = accept_cnt_q;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed bench for des_perm_pipe: permutation vectors, stalls, reset flush, counter wrap.
// Counter is narrowed to 8 bits so the wrap needs only 256 transfers.
module tb_des_perm_pipe;

  localparam int unsigned STAGES = 2;
  localparam int unsigned CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [63:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic             busy;
  logic [CNT_W-1:0] accept_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  des_perm_pipe #(
    .STAGES(STAGES),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .accept_cnt(accept_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [1:0] m, input logic [63:0] d);
    logic got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    for (int t = 0; t < 20 && !got; t++) begin
      #1;
      if (in_ready) got = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("send_accept", {63'b0, got}, 64'd1);
  endtask

  task automatic run_word(input string tag, input logic [1:0] m, input logic [63:0] d,
                          input logic [63:0] exp, output logic [63:0] res);
    int edges;
    out_ready = 1'b1;
    send_word(m, d);
    edges = 1;
    while (!out_valid && edges < 10) begin
      @(negedge clk);
      edges++;
    end
    chk({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
    chk({tag, "_latency"}, 64'(edges), 64'(STAGES));
    chk({tag, "_data"}, out_data, exp);
    res = out_data;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] r;
    logic [63:0] q[$];
    logic [63:0] held;
    logic        stall_prev;
    int          sent;
    int          rcvd;
    int          acc;
    int          cyc;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_data   = '0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_cnt", 64'(accept_cnt), 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rel_out_data", out_data, 64'd0);
    @(negedge clk);

    // Single-word permutation vectors
    run_word("p_msb", 2'b00, 64'h8000_0000_0000_0000, 64'h0080_0000_0000_0000, r);
    run_word("p_b31", 2'b00, 64'h0000_0001_FFFF_FFFF, 64'h0000_0800_0000_0000, r);
    run_word("p_dead", 2'b00, 64'hDEAD_BEEF_1234_5678, 64'hF9BA_9DFF_0000_0000, r);
`ifdef DES_PERM_INVERSE_EN
    run_word("pinv_dead", 2'b11, r, 64'hDEAD_BEEF_0000_0000, r);
`else
    run_word("bypass", 2'b11, 64'hDEAD_BEEF_1234_5678, 64'hDEAD_BEEF_1234_5678, r);
`endif
    run_word("ip_b57", 2'b01, 64'h0000_0000_0000_0040, 64'h8000_0000_0000_0000, r);
    run_word("ip_b0", 2'b01, 64'h8000_0000_0000_0000, 64'h0000_0000_0100_0000, r);
    run_word("fp_b0", 2'b10, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0040, r);
    run_word("ip_vec", 2'b01, 64'h0123_4567_89AB_CDEF, 64'hCC00_CCFF_F0AA_F0AA, r);
    run_word("fp_back", 2'b10, r, 64'h0123_4567_89AB_CDEF, r);

    // Reset with two words in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b01;
    in_data   = 64'h0000_0000_0000_0040;
    @(negedge clk);
    in_data = 64'h0000_0000_0000_4000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("inflight_valid", {63'b0, out_valid}, 64'd1);
    chk("inflight_busy", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_cnt", 64'(accept_cnt), 64'd0);
    chk("mid_rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("mid_rst_out_data", out_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_in_ready", {63'b0, in_ready}, 64'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_stale_valid", {63'b0, out_valid}, 64'd0);
    end

    // Eight back-to-back words, consumer stalled during cycles 3..6
    sent       = 0;
    rcvd       = 0;
    stall_prev = 1'b0;
    held       = '0;
    for (int c = 0; c < 40 && rcvd < 8; c++) begin
      if (stall_prev) begin
        chk("stall_valid", {63'b0, out_valid}, 64'd1);
        chk("stall_data", out_data, held);
      end
      out_ready = !(c >= 3 && c <= 6);
      in_valid  = (sent < 8);
      in_mode   = 2'b01;
      in_data   = 64'h40 << (8 * sent);
      #1;
      if (out_valid && out_ready) begin
        chk($sformatf("stream_word%0d", rcvd), out_data, q.pop_front());
        rcvd++;
      end
      stall_prev = out_valid && !out_ready;
      held       = out_data;
      if (in_valid && in_ready) begin
        q.push_back(64'h8000_0000_0000_0000 >> sent);
        sent++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stream_sent", 64'(sent), 64'd8);
    chk("stream_rcvd", 64'(rcvd), 64'd8);
    chk("stream_cnt", 64'(accept_cnt), 64'd8);

    // Idle inputs with junk data must not create words
    in_mode = 2'b11;
    for (int c = 0; c < 3; c++) begin
      in_data = 64'hA5A5_0000_FFFF_0000 ^ 64'(c);
      @(negedge clk);
    end
    chk("idle_busy", {63'b0, busy}, 64'd0);
    chk("idle_valid", {63'b0, out_valid}, 64'd0);

    // Full-rate stream to wrap the counter: 248 more transfers from 8
    acc       = 8;
    cyc       = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 2'b10;
    for (int c = 0; c < 600 && acc < 256; c++) begin
      in_data = 64'(c) * 64'h0101_0101_0101_0101;
      #1;
      if (in_ready) acc++;
      cyc++;
      @(negedge clk);
      if (acc == 255) chk("cnt_255", 64'(accept_cnt), 64'd255);
    end
    in_valid = 1'b0;
    chk("wrap_accepts", 64'(acc), 64'd256);
    chk("wrap_rate", 64'(cyc), 64'd248);
    chk("cnt_wrap", 64'(accept_cnt), 64'd0);
    for (int c = 0; c < STAGES + 1; c++) @(negedge clk);
    chk("drain_busy", {63'b0, busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/des_perm_pipe.md
DES_PERM_PIPE -- requirements
Module: des_perm_pipe

Interface
REQ-001 SHALL have parameter STAGES, default 2, number of register stages (legal 1..4).
REQ-002 SHALL have parameter CNT_W, default 16, width of the accepted-word counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  input word present.
REQ-006 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-007 SHALL have port in_mode  input  2  permutation select, sampled with the word.
REQ-008 SHALL have port in_data  input  64  bit 0 = MSB, FIPS 46-3 numbering minus one.
REQ-009 SHALL have port out_valid  output  1  result word present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port out_data  output  64  permuted word.
REQ-012 SHALL have port busy  output  1  any stage holds a valid word.
REQ-013 SHALL have port accept_cnt  output  CNT_W  count of accepted input words.

Function
REQ-014 SHALL apply permutations per FIPS 46-3: output bit i = input bit (T[i]-1).
REQ-015 SHALL treat in_mode 00 as P-box on in_data[0:31], with out_data[0:31] = result and out_data[32:63] = 0.
REQ-016 SHALL treat in_mode 01 as initial permutation IP on all 64 bits.
REQ-017 SHALL treat in_mode 10 as final permutation FP (IP inverse) on all 64 bits.
REQ-018 SHALL treat in_mode 11 as defined under Configuration.
REQ-019 SHALL apply the permutation combinationally ahead of stage 1; stages 2..STAGES are pure delay.
REQ-020 SHALL have a latency of STAGES cycles from the accepting edge to out_valid, with no stalls.
REQ-021 SHALL transfer a word at input when in_valid and in_ready are both high; at output when out_valid and out_ready are both high.
REQ-022 SHALL drive in_ready = NOT(stage1 valid) OR stage1 advancing; the pipeline is elastic, and bubbles collapse when downstream is stalled.
REQ-023 SHALL sustain 1 word/cycle with out_ready held high.
REQ-024 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL neither lose nor duplicate words; order is preserved.
REQ-026 SHALL support simultaneous accept and output on a full pipeline with no bubble.
REQ-027 SHALL ignore in_data and in_mode when in_valid=0.
REQ-028 SHALL assert busy when any stage valid bit is set.
REQ-029 SHALL increment accept_cnt on each input transfer, wrapping from all-ones to 0.

Reset
REQ-030 SHALL, on rst high, immediately clear all stage valid bits, out_valid, busy and accept_cnt.
REQ-031 SHALL drive out_data to 0 during and after reset until the first word arrives.
REQ-032 SHALL drive in_ready 0 while rst=1 and 1 on the first cycle after release.
REQ-033 SHALL discard in-flight words on reset mid-operation; nothing is emitted afterwards.

Configuration
REQ-034 SHALL use macro DES_PERM_INVERSE_EN: when defined, in_mode 11 = inverse P-box on [0:31], with upper half 0.
REQ-035 SHALL, when DES_PERM_INVERSE_EN is undefined, make in_mode 11 a bypass: out_data = in_data, with identical latency and handshake.

Verification
REQ-036 SHALL cover: mode 00, in_data=0x80000000_00000000 -> out_data=0x00800000_00000000 after STAGES cycles.
REQ-037 SHALL cover: mode 01, in_data=0x00000000_00000040 -> out_data=0x80000000_00000000.
REQ-038 SHALL cover: mode 01 on 0x0123456789ABCDEF, output fed back in mode 10 -> 0x0123456789ABCDEF; with macro, mode 00 then mode 11 on 0xDEADBEEF -> 0xDEADBEEF in the upper half.
REQ-039 SHALL cover: 8 back-to-back words with out_ready low for cycles 3-6 -> all 8 emitted in order, data stable while stalled, accept_cnt=8.
REQ-040 SHALL cover: rst pulsed with 2 words in flight -> out_valid=0 immediately, no stale output, accept_cnt=0, in_ready=1 the cycle after release.
REQ-041 SHALL cover: accept_cnt preloaded by 2^CNT_W transfers -> wraps to 0.
